// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD nibble-bus driver and receiver: FSM states,
// error bit indices, HD44780 command bytes and default timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        PWR,
        HI,
        LO
    } lcd_state_t;

    localparam int unsigned ERR_E_SHORT = 0;
    localparam int unsigned ERR_BUSY    = 1;
    localparam int unsigned ERR_RSRW    = 2;
    localparam int unsigned ERR_INIT    = 3;

    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] HOME     = 8'h02;
    localparam logic [7:0] FUNC_SET = 8'h28;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] DISP_ON  = 8'h0C;

    localparam logic [3:0] INIT_NIBBLE      = 4'h3;
    localparam logic [3:0] INIT_NIBBLE_LAST = 4'h2;

    // 50 MHz clock: 240 ns E pulse, 40 us command, 1.64 ms clear/home.
    localparam int unsigned E_MIN_CYCLES_DEF = 12;
    localparam int unsigned CMD_WAIT_DEF     = 2000;
    localparam int unsigned CLEAR_WAIT_DEF   = 82000;
    localparam int unsigned BUSY_W_DEF       = 17;

    // Clear Display and Return Home (0x02/0x03) run the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == CLEAR || b == HOME || b == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// Panel execution-time counter: load on a new command word, count down to
// zero, busy while nonzero.
module lcd_busy_timer
    import lcd_pkg::*;
#(
    parameter int unsigned W = BUSY_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/lcd_bus_receiver.sv
// Panel-side monitor of the 4-bit Starter Kit LCD bus: init tracking, byte
// reassembly and timing checks. Optional DDRAM model: LCD_BUS_RECEIVER_DDRAM_EN.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int unsigned E_MIN_CYCLES = E_MIN_CYCLES_DEF,
    parameter int unsigned CMD_WAIT     = CMD_WAIT_DEF,
    parameter int unsigned CLEAR_WAIT   = CLEAR_WAIT_DEF,
    parameter int unsigned BUSY_W       = BUSY_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SF_D_8,
    input  logic       SF_D_9,
    input  logic       SF_D_10,
    input  logic       SF_D_11,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
`ifdef LCD_BUS_RECEIVER_DDRAM_EN
    input  logic [4:0] ddram_rd_addr,
    output logic [7:0] ddram_rd_data,
`endif
    output logic       cmd_valid,
    output logic [9:0] cmd_word,
    output logic       init_done,
    output logic       busy,
    output logic [3:0] err
);

    localparam int unsigned EW = $clog2(E_MIN_CYCLES + 1);

    logic          e_r, rs_r, rw_r;
    logic [3:0]    d_r;
    logic          strobe;
    logic [EW-1:0] e_cnt;
    logic [EW:0]   e_width;
    logic          e_short;

    lcd_state_t state, state_nx;
    logic [1:0] step, step_nx;
    logic [3:0] hi_nib, hi_nib_nx;
    logic       rs_hi, rs_hi_nx, rw_hi, rw_hi_nx;
    logic       cmd_valid_nx, init_done_nx;
    logic [9:0] cmd_word_nx;
    logic [3:0] err_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_r  <= 1'b0;
            d_r  <= '0;
            rs_r <= 1'b0;
            rw_r <= 1'b0;
        end else begin
            e_r  <= LCD_E;
            d_r  <= {SF_D_8, SF_D_9, SF_D_10, SF_D_11};
            rs_r <= LCD_RS;
            rw_r <= LCD_RW;
        end
    end

    assign strobe = e_r && !LCD_E;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_cnt <= '0;
        end else if (!e_r) begin
            e_cnt <= '0;
        end else if (e_cnt != '1) begin
            e_cnt <= e_cnt + 1'b1;
        end
    end

    // The strobe edge itself still sees e_r=1, so it counts toward the width.
    assign e_width = {1'b0, e_cnt} + 1'b1;
    assign e_short = (e_width < (EW+1)'(E_MIN_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PWR;
            step      <= '0;
            hi_nib    <= '0;
            rs_hi     <= 1'b0;
            rw_hi     <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_word  <= '0;
            init_done <= 1'b0;
            err       <= '0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            hi_nib    <= hi_nib_nx;
            rs_hi     <= rs_hi_nx;
            rw_hi     <= rw_hi_nx;
            cmd_valid <= cmd_valid_nx;
            cmd_word  <= cmd_word_nx;
            init_done <= init_done_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        step_nx      = step;
        hi_nib_nx    = hi_nib;
        rs_hi_nx     = rs_hi;
        rw_hi_nx     = rw_hi;
        cmd_valid_nx = 1'b0;
        cmd_word_nx  = cmd_word;
        init_done_nx = init_done;
        err_nx       = err;
        if (strobe) begin
            if (e_short) err_nx[ERR_E_SHORT] = 1'b1;
            case (state)
                PWR: begin
                    if (d_r == ((step == 2'd3) ? INIT_NIBBLE_LAST : INIT_NIBBLE)) begin
                        if (step == 2'd3) begin
                            init_done_nx = 1'b1;
                            step_nx      = '0;
                            state_nx     = HI;
                        end else begin
                            step_nx = step + 2'd1;
                        end
                    end else begin
                        err_nx[ERR_INIT] = 1'b1;
                        step_nx          = '0;
                    end
                end
                HI: begin
                    if (busy) err_nx[ERR_BUSY] = 1'b1;
                    hi_nib_nx = d_r;
                    rs_hi_nx  = rs_r;
                    rw_hi_nx  = rw_r;
                    state_nx  = LO;
                end
                LO: begin
                    if (rs_r != rs_hi || rw_r != rw_hi) err_nx[ERR_RSRW] = 1'b1;
                    cmd_valid_nx = 1'b1;
                    cmd_word_nx  = {rs_hi, rw_hi, hi_nib, d_r};
                    state_nx     = HI;
                end
                default: state_nx = PWR;
            endcase
        end
    end

    lcd_busy_timer #(
        .W(BUSY_W)
    ) u_busy_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (cmd_valid),
        .load_val(is_long_cmd(cmd_word[9], cmd_word[7:0]) ? BUSY_W'(CLEAR_WAIT)
                                                          : BUSY_W'(CMD_WAIT)),
        .busy    (busy)
    );

`ifdef LCD_BUS_RECEIVER_DDRAM_EN
    logic [7:0] ddram [32];
    logic [4:0] addr;
    logic       clr_run;
    logic [4:0] clr_idx;
    logic       data_wr;

    assign data_wr = cmd_valid && (cmd_word[9:8] == 2'b10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr    <= '0;
            clr_run <= 1'b0;
            clr_idx <= '0;
        end else begin
            if (clr_run) begin
                clr_idx <= clr_idx + 5'd1;
                if (clr_idx == 5'd31) clr_run <= 1'b0;
            end
            if (cmd_valid && !cmd_word[9]) begin
                if (cmd_word[7:0] == CLEAR) begin
                    addr    <= '0;
                    clr_run <= 1'b1;
                    clr_idx <= '0;
                end else if (cmd_word[7:1] == 7'h01) begin
                    addr <= '0;
                end else if (cmd_word[7]) begin
                    // Line 2 (DDRAM 0x40) is folded onto entries 16..31.
                    addr <= (cmd_word[6] ? 5'h10 : 5'h00) + {1'b0, cmd_word[3:0]};
                end
            end else if (data_wr) begin
                addr <= addr + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_run) ddram[clr_idx] <= 8'h20;
        if (data_wr) ddram[addr] <= cmd_word[7:0];
        ddram_rd_data <= ddram[ddram_rd_addr];
    end
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboard bench for lcd_bus_receiver: expected command words are queued as
// bytes are driven and popped when cmd_valid pulses.
module tb_lcd_bus_receiver;

    localparam int unsigned CMD_W = 2000;
    localparam int unsigned CLR_W = 8200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SF_D_8 = 1'b0, SF_D_9 = 1'b0, SF_D_10 = 1'b0, SF_D_11 = 1'b0;
    logic       LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
    logic       cmd_valid;
    logic [9:0] cmd_word;
    logic       init_done;
    logic       busy;
    logic [3:0] err;
`ifdef LCD_BUS_RECEIVER_DDRAM_EN
    logic [4:0] ddram_rd_addr = '0;
    logic [7:0] ddram_rd_data;
`endif

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned strobe_cyc = 0;
    logic [9:0]  exp_q[$];

    lcd_bus_receiver #(
        .E_MIN_CYCLES(12),
        .CMD_WAIT    (CMD_W),
        .CLEAR_WAIT  (CLR_W),
        .BUSY_W      (17)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .SF_D_8   (SF_D_8),
        .SF_D_9   (SF_D_9),
        .SF_D_10  (SF_D_10),
        .SF_D_11  (SF_D_11),
        .LCD_E    (LCD_E),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
`ifdef LCD_BUS_RECEIVER_DDRAM_EN
        .ddram_rd_addr(ddram_rd_addr),
        .ddram_rd_data(ddram_rd_data),
`endif
        .cmd_valid(cmd_valid),
        .cmd_word (cmd_word),
        .init_done(init_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && cmd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_cmd_valid", {31'b0, cmd_valid}, 32'h0);
            end else begin
                check("cmd_word", {22'b0, cmd_word}, {22'b0, exp_q.pop_front()});
                check("cmd_latency", cyc, strobe_cyc);
            end
        end
    end

    task automatic nibble(input logic [3:0] n, input logic rs, input logic rw, input int e_len);
        @(posedge clk); #1;
        {SF_D_8, SF_D_9, SF_D_10, SF_D_11} = n;
        LCD_RS = rs;
        LCD_RW = rw;
        @(posedge clk); #1;
        LCD_E = 1'b1;
        repeat (e_len) @(posedge clk);
        #1 LCD_E = 1'b0;
        @(posedge clk); #1;
        strobe_cyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs, input logic rw);
        exp_q.push_back({rs, rw, b});
        nibble(b[7:4], rs, rw, 12);
        nibble(b[3:0], rs, rw, 12);
    endtask

    task automatic do_init();
        nibble(4'h3, 1'b0, 1'b0, 12);
        nibble(4'h3, 1'b0, 1'b0, 12);
        nibble(4'h3, 1'b0, 1'b0, 12);
        nibble(4'h2, 1'b0, 1'b0, 12);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic busy_len(input string tag, input int unsigned exp_len);
        int unsigned n = 0;
        check({tag, "_start"}, {31'b0, busy}, 32'h1);
        while (busy === 1'b1 && n < 3 * CLR_W) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, n, exp_len);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (busy === 1'b1 && n < 3 * CLR_W) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
        check("rst_cmd_word", {22'b0, cmd_word}, 32'h0);
        check("rst_init_done", {31'b0, init_done}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_err", {28'b0, err}, 32'h0);
        reset = 1'b0;

        // Power-on sequence
        nibble(4'h3, 1'b0, 1'b0, 12);
        nibble(4'h3, 1'b0, 1'b0, 12);
        nibble(4'h3, 1'b0, 1'b0, 12);
        check("init_done_early", {31'b0, init_done}, 32'h0);
        nibble(4'h2, 1'b0, 1'b0, 12);
        check("init_done", {31'b0, init_done}, 32'h1);
        check("init_err", {28'b0, err}, 32'h0);

        // Function set and its execution time
        send_byte(8'h28, 1'b0, 1'b0);
        busy_len("busy_len_cmd", CMD_W);

        // Command during a clear's long busy time
        send_byte(8'h01, 1'b0, 1'b0);
        repeat (1000) @(posedge clk);
        #1;
        send_byte(8'h06, 1'b0, 1'b0);
        check("err_busy_set", {28'b0, err}, 32'h2);
        wait_idle();

        // Same after the full clear time
        do_reset();
        do_init();
        send_byte(8'h01, 1'b0, 1'b0);
        busy_len("busy_len_clear", CLR_W);
        @(posedge clk); #1;
        send_byte(8'h06, 1'b0, 1'b0);
        check("err_busy_clear", {28'b0, err}, 32'h0);
        wait_idle();

        // Short E pulse on the high nibble
        exp_q.push_back(10'h241);
        nibble(4'h4, 1'b1, 1'b0, 5);
        nibble(4'h1, 1'b1, 1'b0, 12);
        check("err_e_short", {28'b0, err}, 32'h1);
        wait_idle();

        // RS differs between nibbles: high-nibble RS kept
        exp_q.push_back(10'h25A);
        nibble(4'h5, 1'b1, 1'b0, 12);
        nibble(4'hA, 1'b0, 1'b0, 12);
        check("err_rsrw", {28'b0, err}, 32'h5);
        wait_idle();

        // Read transfer decoded like a write
        send_byte(8'hC3, 1'b0, 1'b1);
        busy_len("busy_len_rw", CMD_W);
        check("err_after_rw", {28'b0, err}, 32'h5);

        // Bad init nibble, then a clean sequence
        do_reset();
        nibble(4'h3, 1'b0, 1'b0, 12);
        nibble(4'h5, 1'b0, 1'b0, 12);
        check("err_init", {28'b0, err}, 32'h8);
        check("init_done_bad", {31'b0, init_done}, 32'h0);
        do_init();
        check("init_done_retry", {31'b0, init_done}, 32'h1);
        check("err_init_sticky", {28'b0, err}, 32'h8);

        // Reset between high and low nibble
        send_byte(8'h0C, 1'b0, 1'b0);
        wait_idle();
        nibble(4'h2, 1'b0, 1'b0, 12);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cmd_word", {22'b0, cmd_word}, 32'h0);
        check("mid_rst_init_done", {31'b0, init_done}, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_err", {28'b0, err}, 32'h0);
        check("mid_rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        nibble(4'h3, 1'b0, 1'b0, 12);
        nibble(4'h3, 1'b0, 1'b0, 12);
        check("post_rst_init_done", {31'b0, init_done}, 32'h0);
        check("post_rst_err", {28'b0, err}, 32'h0);
        nibble(4'h3, 1'b0, 1'b0, 12);
        nibble(4'h2, 1'b0, 1'b0, 12);
        check("post_rst_init", {31'b0, init_done}, 32'h1);
        send_byte(8'h06, 1'b0, 1'b0);
        busy_len("busy_len_entry", CMD_W);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
